coin_settle: RTL

COIN_SETTLE -- requirements
Module: coin_settle

---
 rtl/wm_pkg.sv | 19 +
 rtl/bcd3_addsub.sv | 43 ++++
 rtl/coin_settle.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/wm_pkg.sv
// Shared definitions for the wash-machine stages.
// Covers the settle FSM state codes, programme codes and the BCD ceiling.
package wm_pkg;

    typedef logic [11:0] bcd3_t;

    localparam bcd3_t BCD_MAX = 12'h999;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ALARM  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic [1:0] MODE_DRY    = 2'd0;
    localparam logic [1:0] MODE_SMALL  = 2'd1;
    localparam logic [1:0] MODE_MEDIUM = 2'd2;
    localparam logic [1:0] MODE_BIG    = 2'd3;

endpackage

// File: rtl/bcd3_addsub.sv
// Combinational 3-digit BCD adder/subtractor with digit-wise carry/borrow.
// Addition saturates at 999; subtraction clamps to 000 and raises the flag on borrow.
module bcd3_addsub
    import wm_pkg::*;
(
    input  logic [11:0] a,
    input  logic [11:0] b,
    input  logic        sub,
    output logic [11:0] result,
    output logic        flag
);

    logic [3:0]  carry;
    logic [11:0] raw;

    assign carry[0] = 1'b0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_digit
        logic [4:0] sum_raw;
        logic [4:0] dif_raw;
        logic       add_c;

        assign sum_raw = {1'b0, a[gi*4 +: 4]} + {1'b0, b[gi*4 +: 4]} + {4'b0, carry[gi]};
        assign dif_raw = {1'b0, a[gi*4 +: 4]} - {1'b0, b[gi*4 +: 4]} - {4'b0, carry[gi]};
        assign add_c   = (sum_raw >= 5'd10);

        // dif_raw lies in -10..9, so bit 4 is the sign of the digit difference
        always_comb begin
            raw[gi*4 +: 4] = sum_raw[3:0];
            if (sub) begin
                raw[gi*4 +: 4] = dif_raw[4] ? (dif_raw[3:0] + 4'd10) : dif_raw[3:0];
            end else if (add_c) begin
                raw[gi*4 +: 4] = sum_raw[3:0] - 4'd10;
            end
        end

        assign carry[gi+1] = sub ? dif_raw[4] : add_c;
    end

    assign flag   = carry[3];
    assign result = flag ? (sub ? 12'h000 : BCD_MAX) : raw;

endmodule

// File: rtl/coin_settle.sv
// Post-wash payment stage: buzzes until pickup, accrues overtime fine per second,
// then settles price + fine against the user balance and holds the result.
module coin_settle
    import wm_pkg::*;
#(
    parameter int CLK_HZ   = 100000000,
    parameter int GRACE_S  = 3,
    parameter int BUZ_HALF = CLK_HZ / 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [11:0] price_dy,
    input  logic [11:0] price_s,
    input  logic [11:0] price_m,
    input  logic [11:0] price_b,
    input  logic [11:0] fine_rate,
    input  logic [11:0] bal,
    input  logic        confirm,
    output logic        busy,
    output logic        buzzer,
    output logic [11:0] fine,
    output logic [11:0] charge,
    output logic [11:0] change,
    output logic        short,
    output logic [11:0] income,
    output logic        income_valid,
    output logic        done
);

    localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BW = (BUZ_HALF > 1) ? $clog2(BUZ_HALF) : 1;
    localparam int SW = (GRACE_S > 0) ? $clog2(GRACE_S + 1) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BUZ_LAST  = BW'(BUZ_HALF - 1);
    localparam logic [SW-1:0] SEC_MAX   = SW'(GRACE_S);

    logic [1:0]    state_reg;
    logic [TW-1:0] tick_cnt_reg;
    logic [BW-1:0] buz_cnt_reg;
    logic [SW-1:0] sec_reg;
    bcd3_t         price_reg, rate_reg, bal_reg, fine_reg;
    bcd3_t         charge_reg, change_reg, income_reg;
    logic          short_reg, buzzer_reg, income_valid_reg, done_reg;

    bcd3_t         price_sel, fine_sum, charge_sum, change_diff;
    logic          fine_sat, charge_sat, change_borrow;
    logic          tick;

    always_comb begin
        price_sel = price_dy;
        case (mode)
            MODE_SMALL:  price_sel = price_s;
            MODE_MEDIUM: price_sel = price_m;
            MODE_BIG:    price_sel = price_b;
            default:     price_sel = price_dy;
        endcase
    end

    assign tick = (state_reg == ST_ALARM) && (tick_cnt_reg == TICK_LAST);

    bcd3_addsub u_fine (
        .a      (fine_reg),
        .b      (rate_reg),
        .sub    (1'b0),
        .result (fine_sum),
        .flag   (fine_sat)
    );

    bcd3_addsub u_charge (
        .a      (price_reg),
        .b      (fine_reg),
        .sub    (1'b0),
        .result (charge_sum),
        .flag   (charge_sat)
    );

    // Compares the balance against the freshly saturated charge, not the stale register
    bcd3_addsub u_change (
        .a      (bal_reg),
        .b      (charge_sum),
        .sub    (1'b1),
        .result (change_diff),
        .flag   (change_borrow)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= ST_IDLE;
            tick_cnt_reg     <= '0;
            buz_cnt_reg      <= '0;
            sec_reg          <= '0;
            price_reg        <= '0;
            rate_reg         <= '0;
            bal_reg          <= '0;
            fine_reg         <= '0;
            charge_reg       <= '0;
            change_reg       <= '0;
            income_reg       <= '0;
            short_reg        <= 1'b0;
            buzzer_reg       <= 1'b0;
            income_valid_reg <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            income_valid_reg <= 1'b0;
            done_reg         <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        price_reg    <= price_sel;
                        rate_reg     <= fine_rate;
                        bal_reg      <= bal;
                        fine_reg     <= '0;
                        sec_reg      <= '0;
                        tick_cnt_reg <= '0;
                        buz_cnt_reg  <= '0;
                        buzzer_reg   <= 1'b1;
                        state_reg    <= ST_ALARM;
                    end
                end
                ST_ALARM: begin
                    // A pickup in the same cycle as a tick discards that tick's fine
                    if (confirm) begin
                        buzzer_reg <= 1'b0;
                        state_reg  <= ST_SETTLE;
                    end else begin
                        tick_cnt_reg <= tick ? '0 : tick_cnt_reg + TW'(1);
                        if (tick) begin
                            if (sec_reg == SEC_MAX) begin
                                fine_reg <= fine_sum;
                            end else begin
                                sec_reg <= sec_reg + SW'(1);
                            end
                        end
                        if (buz_cnt_reg == BUZ_LAST) begin
                            buz_cnt_reg <= '0;
                            buzzer_reg  <= ~buzzer_reg;
                        end else begin
                            buz_cnt_reg <= buz_cnt_reg + BW'(1);
                        end
                    end
                end
                ST_SETTLE: begin
                    charge_reg <= charge_sum;
                    if (!change_borrow) begin
                        change_reg <= change_diff;
                        income_reg <= charge_sum;
                        short_reg  <= 1'b0;
                    end else begin
                        change_reg <= '0;
                        income_reg <= bal_reg;
                        short_reg  <= 1'b1;
                    end
                    income_valid_reg <= 1'b1;
                    state_reg        <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (confirm) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy         = (state_reg != ST_IDLE);
    assign buzzer       = buzzer_reg;
    assign fine         = fine_reg;
    assign charge       = charge_reg;
    assign change       = change_reg;
    assign short        = short_reg;
    assign income       = income_reg;
    assign income_valid = income_valid_reg;
    assign done         = done_reg;

endmodule
